phase_select_ctrl: RTL and testbench

PHASE_SELECT_CTRL -- requirements
Module: phase_select_ctrl

---
 rtl/phase_select_ctrl.sv | 150 +++++++++++++++
 tb/tb_phase_select_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_select_ctrl.sv
// Glitch-free 4-phase clock selector: a quadrature legality monitor gates
// requests, and a drain/park/commit sequence moves the output between phases.
module phase_select_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ph_in,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic       done,
  output logic       abort,
  output logic [1:0] cur_sel,
  output logic       phase_out,
  output logic       lock,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DRAIN, PARK, COMMIT} state_t;

  state_t     state_q, state_d;
  logic [1:0] cur_sel_q, cur_sel_d;
  logic [1:0] nxt_sel_q, nxt_sel_d;
  logic       phase_out_q, phase_out_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic       lock_q, lock_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] run_q, run_d;
  logic [3:0] tmo_q, tmo_d;
  logic [1:0] prev_q, prev_d;
  logic       first_q, first_d;

  logic       cmp_ok;
  logic       toggle_ok;
  logic       legal;
  logic       accept;
  logic       timeout;
  logic [3:0] tmo_inc;
  logic [1:0] out_sel;

  assign req_ready = (state_q == IDLE) && lock_q;
  assign accept    = req_valid && req_ready;

  // Only the 0/90 degree bits carry information; the upper pair must mirror them.
  always_comb begin
    cmp_ok    = (ph_in[2] == ~ph_in[0]) && (ph_in[3] == ~ph_in[1]);
    toggle_ok = ^(ph_in[1:0] ^ prev_q);
    legal     = cmp_ok && (first_q || toggle_ok);
    prev_d    = ph_in[1:0];
    first_d   = 1'b0;
    if (!legal)
      run_d = 4'd0;
    else if (run_q == 4'd8)
      run_d = run_q;
    else
      run_d = run_q + 4'd1;
    lock_d = (run_d == 4'd8);
    if (!legal && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
    else
      err_cnt_d = err_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    nxt_sel_d = nxt_sel_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    tmo_inc   = tmo_q + 4'd1;
    timeout   = (tmo_inc == 4'd8);
    case (state_q)
      IDLE: begin
        if (accept) begin
          nxt_sel_d = req_sel;
          tmo_d     = 4'd0;
          state_d   = (req_sel == cur_sel_q) ? COMMIT : DRAIN;
        end
      end
      DRAIN: begin
        tmo_d = tmo_inc;
        if (!lock_q || timeout) begin
          done_d  = 1'b1;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (!ph_in[cur_sel_q]) begin
          state_d = PARK;
        end
      end
      PARK: begin
        tmo_d = tmo_inc;
        if (!lock_q || timeout) begin
          done_d  = 1'b1;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (!ph_in[nxt_sel_q]) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        cur_sel_d = nxt_sel_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // COMMIT already follows the new phase so the low gap from PARK is not cut short.
    out_sel     = (state_q == COMMIT) ? nxt_sel_q : cur_sel_q;
    phase_out_d = (state_q == PARK) ? 1'b0 : ph_in[out_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_sel_q   <= 2'd0;
      nxt_sel_q   <= 2'd0;
      phase_out_q <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      lock_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
      run_q       <= 4'd0;
      tmo_q       <= 4'd0;
      prev_q      <= 2'd0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      nxt_sel_q   <= nxt_sel_d;
      phase_out_q <= phase_out_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      lock_q      <= lock_d;
      err_cnt_q   <= err_cnt_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
    end
  end

  assign done      = done_q;
  assign abort     = abort_q;
  assign cur_sel   = cur_sel_q;
  assign phase_out = phase_out_q;
  assign lock      = lock_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_phase_select_ctrl.sv
// Directed bench for phase_select_ctrl: locking, switching, aborts, saturation
// and reset behaviour against hand-computed expectations.
module tb_phase_select_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ph_in;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       done;
  logic       abort;
  logic [1:0] cur_sel;
  logic       phase_out;
  logic       lock;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int qi    = 0;
  logic [3:0] quad [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};

  phase_select_ctrl dut (
    .clk(clk), .rst(rst), .ph_in(ph_in), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .done(done), .abort(abort), .cur_sel(cur_sel),
    .phase_out(phase_out), .lock(lock), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [3:0] ph);
    ph_in = ph;
    @(posedge clk);
    #1;
  endtask

  task automatic qtick();
    tick(quad[qi]);
    qi = (qi + 1) % 4;
  endtask

  task automatic test_reset();
    rst = 1'b1; ph_in = 4'b0000; req_valid = 1'b0; req_sel = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    total++; if ({done, abort, cur_sel, phase_out, lock, err_cnt, req_ready} !== 14'd0) begin bad++; $display("FAIL reset_outputs: got %b want 0", {done, abort, cur_sel, phase_out, lock, err_cnt, req_ready}); end
    rst = 1'b0;
  endtask

  // Starting on 1100 matches the reset sample, so only the first-cycle rule makes it legal.
  task automatic test_lock();
    logic exp_po;
    qi = 3;
    for (int i = 1; i <= 9; i++) begin
      exp_po = quad[qi][0];
      qtick();
      total++; if (phase_out !== exp_po) begin bad++; $display("FAIL lock_track_po[%0d]: got %b want %b", i, phase_out, exp_po); end
      if (i == 7) begin
        total++; if (lock !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", lock); end
      end
      if (i >= 8) begin
        total++; if (lock !== 1'b1) begin bad++; $display("FAIL lock_set[%0d]: got %b want 1", i, lock); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lock_ready[%0d]: got %b want 1", i, req_ready); end
      end
    end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL lock_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_switch(input string name, input logic [1:0] sel, input logic [7:0] po,
                             input logic [7:0] dn, input logic [7:0] rdy, input logic [15:0] cs);
    req_sel = sel; req_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      qtick();
      req_valid = 1'b0;
      total++; if (phase_out !== po[t]) begin bad++; $display("FAIL %s_po[t%0d]: got %b want %b", name, t + 1, phase_out, po[t]); end
      total++; if (done !== dn[t]) begin bad++; $display("FAIL %s_done[t%0d]: got %b want %b", name, t + 1, done, dn[t]); end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL %s_abort[t%0d]: got %b want 0", name, t + 1, abort); end
      total++; if (req_ready !== rdy[t]) begin bad++; $display("FAIL %s_ready[t%0d]: got %b want %b", name, t + 1, req_ready, rdy[t]); end
      total++; if (cur_sel !== cs[2*t +: 2]) begin bad++; $display("FAIL %s_cur[t%0d]: got %0d want %0d", name, t + 1, cur_sel, cs[2*t +: 2]); end
    end
  endtask

  // The second request lands while the FSM sits in COMMIT and must be dropped.
  task automatic test_same_sel();
    logic       po [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       dn [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       rd [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    req_sel = 2'd1; req_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      qtick();
      req_sel = 2'd3;
      req_valid = (t == 0);
      total++; if (phase_out !== po[t]) begin bad++; $display("FAIL same_po[t%0d]: got %b want %b", t + 1, phase_out, po[t]); end
      total++; if (done !== dn[t]) begin bad++; $display("FAIL same_done[t%0d]: got %b want %b", t + 1, done, dn[t]); end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL same_abort[t%0d]: got %b want 0", t + 1, abort); end
      total++; if (req_ready !== rd[t]) begin bad++; $display("FAIL same_ready[t%0d]: got %b want %b", t + 1, req_ready, rd[t]); end
      total++; if (cur_sel !== 2'd1) begin bad++; $display("FAIL same_cur[t%0d]: got %0d want 1", t + 1, cur_sel); end
    end
  endtask

  task automatic test_lock_loss();
    int done_seen = 0;
    req_sel = 2'd0; req_valid = 1'b1;
    tick(4'b1001);
    req_valid = 1'b0;
    tick(4'b0101);
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL loss_lock: got %b want 0", lock); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL loss_done_early: got %b want 0", done); end
    tick(4'b0101);
    total++; if ({done, abort} !== 2'b11) begin bad++; $display("FAIL loss_abort: got %b want 11", {done, abort}); end
    total++; if (cur_sel !== 2'd2) begin bad++; $display("FAIL loss_cur: got %0d want 2", cur_sel); end
    req_valid = 1'b1; req_sel = 2'd3;
    tick(4'b0101);
    req_valid = 1'b0;
    total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL loss_err: got %0d want 3", err_cnt); end
    total++; if ({done, req_ready} !== 2'b00) begin bad++; $display("FAIL loss_after: got %b want 00", {done, req_ready}); end
    qi = 1;
    for (int i = 0; i < 8; i++) begin
      qtick();
      if (done === 1'b1) done_seen++;
    end
    total++; if ({lock, req_ready} !== 2'b11) begin bad++; $display("FAIL loss_relock: got %b want 11", {lock, req_ready}); end
    total++; if (cur_sel !== 2'd2 || err_cnt !== 8'd3) begin bad++; $display("FAIL loss_relock_state: got cur=%0d err=%0d want cur=2 err=3", cur_sel, err_cnt); end
    total++; if (done_seen != 0) begin bad++; $display("FAIL loss_ignored_req: got %0d done pulses want 0", done_seen); end
  endtask

  task automatic test_freeze();
    int done_seen = 0;
    req_sel = 2'd0; req_valid = 1'b1;
    qtick();
    req_valid = 1'b0;
    qtick(); qtick(); qtick();
    total++; if ({phase_out, req_ready} !== 2'b00) begin bad++; $display("FAIL freeze_park: got %b want 00", {phase_out, req_ready}); end
    for (int f = 1; f <= 300; f++) begin
      tick(4'b0011);
      if (done === 1'b1) done_seen++;
      if (f == 2) begin
        total++; if ({lock, phase_out, done} !== 3'b000) begin bad++; $display("FAIL freeze_drop: got %b want 000", {lock, phase_out, done}); end
        total++; if (err_cnt !== 8'd4) begin bad++; $display("FAIL freeze_err4: got %0d want 4", err_cnt); end
      end
      if (f == 3) begin
        total++; if ({done, abort, cur_sel} !== 4'b1110) begin bad++; $display("FAIL freeze_abort: got %b want 1110", {done, abort, cur_sel}); end
      end
    end
    total++; if (done_seen != 1) begin bad++; $display("FAIL freeze_pulses: got %0d want 1", done_seen); end
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL freeze_sat: got %0d want 255", err_cnt); end
  endtask

  // Toggling only the 90 degree bit keeps the 180 degree phase high, so DRAIN never finishes.
  task automatic test_timeout();
    for (int i = 0; i < 8; i++) tick((i % 2 == 0) ? 4'b0110 : 4'b1100);
    total++; if ({lock, req_ready} !== 2'b11) begin bad++; $display("FAIL tmo_lock: got %b want 11", {lock, req_ready}); end
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL tmo_err_hold: got %0d want 255", err_cnt); end
    req_sel = 2'd0; req_valid = 1'b1;
    tick(4'b0110);
    req_sel = 2'd1;
    for (int t = 2; t <= 9; t++) begin
      tick((t % 2 == 0) ? 4'b1100 : 4'b0110);
      if (t == 8) begin
        total++; if ({done, req_ready} !== 2'b00) begin bad++; $display("FAIL tmo_early: got %b want 00", {done, req_ready}); end
      end
    end
    total++; if ({done, abort, cur_sel} !== 4'b1110) begin bad++; $display("FAIL tmo_abort: got %b want 1110", {done, abort, cur_sel}); end
    req_valid = 1'b0;
    tick(4'b1100);
    total++; if ({done, req_ready, lock} !== 3'b011) begin bad++; $display("FAIL tmo_idle: got %b want 011", {done, req_ready, lock}); end
    qi = 0;
  endtask

  task automatic test_reset_mid_park();
    int done_seen = 0;
    req_sel = 2'd1; req_valid = 1'b1;
    qtick();
    req_valid = 1'b0;
    qtick(); qtick();
    total++; if ({phase_out, req_ready} !== 2'b00) begin bad++; $display("FAIL rpark_park: got %b want 00", {phase_out, req_ready}); end
    #2 rst = 1'b1;
    #1;
    total++; if ({done, abort, cur_sel, phase_out, lock, err_cnt, req_ready} !== 14'd0) begin bad++; $display("FAIL rpark_async: got %b want 0", {done, abort, cur_sel, phase_out, lock, err_cnt, req_ready}); end
    tick(4'b1100); tick(4'b1100);
    total++; if ({done, abort, cur_sel, phase_out, lock, err_cnt, req_ready} !== 14'd0) begin bad++; $display("FAIL rpark_held: got %b want 0", {done, abort, cur_sel, phase_out, lock, err_cnt, req_ready}); end
    rst = 1'b0;
    qi = 0;
    for (int i = 1; i <= 8; i++) begin
      qtick();
      if (done === 1'b1) done_seen++;
      if (i == 7) begin
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rpark_ready_early: got %b want 0", req_ready); end
      end
    end
    total++; if ({lock, req_ready} !== 2'b11) begin bad++; $display("FAIL rpark_relock: got %b want 11", {lock, req_ready}); end
    total++; if (cur_sel !== 2'd0 || err_cnt !== 8'd0) begin bad++; $display("FAIL rpark_state: got cur=%0d err=%0d want 0 0", cur_sel, err_cnt); end
    total++; if (done_seen != 0) begin bad++; $display("FAIL rpark_no_done: got %0d want 0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_switch("sw0to2", 2'd2, 8'b11000011, 8'b00100000, 8'b11100000, 16'hA800);
    test_switch("sw2to1", 2'd1, 8'b01100000, 8'b00010000, 8'b11110000, 16'h55AA);
    test_same_sel();
    test_switch("sw1to2", 2'd2, 8'b11000110, 8'b00100000, 8'b11100000, 16'hA955);
    test_lock_loss();
    test_freeze();
    test_timeout();
    test_reset_mid_park();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
